// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and helpers for the multi-port register file.
//   DEF_*          default values for the regfile_mp parameters
//   MAX_*          largest port count / data width / address width that the
//                  priority helper can handle (callers zero-extend into these)
//   write_hit_t    result of a priority lookup: hit flag plus winning data
//   winning_write  returns the hit flag and data of the highest-index write
//                  port targeting a given address
// ----------------------------------------------------------------------------
package regfile_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_DEPTH  = 32;
   localparam int DEF_NREAD  = 2;
   localparam int DEF_NWRITE = 1;

   localparam int MAX_PORTS  = 8;
   localparam int MAX_WIDTH  = 64;
   localparam int MAX_AW     = 16;

   typedef struct packed {
      logic                 hit;
      logic [MAX_WIDTH-1:0] data;
   } write_hit_t;

   // Ports are scanned in ascending order so a later (higher-index) port
   // overwrites the result of an earlier one: the highest index wins.
   // Used by both the storage update and the read bypass so that the two
   // can never disagree about which port owns an address.
   function automatic write_hit_t winning_write(
      input logic [MAX_PORTS-1:0]                we,
      input logic [MAX_PORTS-1:0][MAX_AW-1:0]    wa,
      input logic [MAX_PORTS-1:0][MAX_WIDTH-1:0] wd,
      input logic [MAX_AW-1:0]                   addr
   );
      write_hit_t res;
      res.hit  = 1'b0;
      res.data = '0;
      for (int p = 0; p < MAX_PORTS; p++) begin
         if (we[p] && (wa[p] == addr)) begin
            res.hit  = 1'b1;
            res.data = wd[p];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
// Busy bit per register, tracking registers that await write-back.
//   clk, rst_n   clock, asynchronous active-low reset
//   we, wa       write ports; a write to an address clears its busy bit
//   rsv_en       reserve request, rsv_addr is the register to mark busy
//   busy         registered scoreboard vector
//   busy_next    value busy takes at the next edge (for read-port sampling)
// ----------------------------------------------------------------------------
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int DEPTH    = DEF_DEPTH,
   parameter  int NWRITE   = DEF_NWRITE,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NWRITE-1:0]          we,
   input  logic [NWRITE-1:0][AW-1:0]  wa,
   input  logic                       rsv_en,
   input  logic [AW-1:0]              rsv_addr,
   output logic [DEPTH-1:0]           busy,
   output logic [DEPTH-1:0]           busy_next
);

   // Clears are applied before the set so that a reservation on the same
   // address as a write-back survives: it belongs to a younger instruction.
   always_comb begin
      busy_next = busy;
      for (int w = 0; w < NWRITE; w++) begin
         if (we[w]) begin
            busy_next[wa[w]] = 1'b0;
         end
      end
      if (rsv_en) begin
         busy_next[rsv_addr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         busy_next[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port register file with write-first bypass and busy
// scoreboard.
//   clk, rst_n   clock, asynchronous active-low reset
//   re, ra       per read port enable and address
//   rd, rd_busy  registered read data and busy flag of the address read
//   we, wa, wd   per write port enable, address and data
//   rsv_en       reserve request, rsv_addr is the register to mark busy
//   busy         live scoreboard vector
// ----------------------------------------------------------------------------
module regfile_mp
   import regfile_pkg::*;
#(
   parameter  int WIDTH    = DEF_WIDTH,
   parameter  int DEPTH    = DEF_DEPTH,
   parameter  int NREAD    = DEF_NREAD,
   parameter  int NWRITE   = DEF_NWRITE,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NREAD-1:0]             re,
   input  logic [NREAD-1:0][AW-1:0]     ra,
   output logic [NREAD-1:0][WIDTH-1:0]  rd,
   output logic [NREAD-1:0]             rd_busy,
   input  logic [NWRITE-1:0]            we,
   input  logic [NWRITE-1:0][AW-1:0]    wa,
   input  logic [NWRITE-1:0][WIDTH-1:0] wd,
   input  logic                         rsv_en,
   input  logic [AW-1:0]                rsv_addr,
   output logic [DEPTH-1:0]             busy
);

   logic [DEPTH-1:0][WIDTH-1:0]         rf;
   logic [DEPTH-1:0]                    busy_next;

   logic [MAX_PORTS-1:0]                we_ext;
   logic [MAX_PORTS-1:0][MAX_AW-1:0]    wa_ext;
   logic [MAX_PORTS-1:0][MAX_WIDTH-1:0] wd_ext;
   logic [DEPTH-1:0]                    wr_hit;
   logic [DEPTH-1:0][WIDTH-1:0]         wr_data;
   write_hit_t                          win_partly_unused;

   // Resolve, for every register, whether some port writes it this edge and
   // which data wins. The write ports are zero-extended to the helper's
   // fixed maximum shape; the helper's data bits above WIDTH are dropped.
   always_comb begin
      we_ext            = '0;
      wa_ext            = '0;
      wd_ext            = '0;
      wr_hit            = '0;
      wr_data           = '0;
      win_partly_unused = '0;
      for (int p = 0; p < NWRITE; p++) begin
         we_ext[p] = we[p];
         wa_ext[p] = MAX_AW'(wa[p]);
         wd_ext[p] = MAX_WIDTH'(wd[p]);
      end
      for (int a = 0; a < DEPTH; a++) begin
         win_partly_unused = winning_write(we_ext, wa_ext, wd_ext, MAX_AW'(a));
         wr_hit[a]         = win_partly_unused.hit;
         wr_data[a]        = win_partly_unused.data[WIDTH-1:0];
      end
   end

   // Storage update; register 0 is left untouched when it is hardwired.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf <= '0;
      end else begin
         for (int a = 0; a < DEPTH; a++) begin
            if (wr_hit[a] && !((ZERO_REG != 0) && (a == 0))) begin
               rf[a] <= wr_data[a];
            end
         end
      end
   end

   regfile_scoreboard #(
      .DEPTH    (DEPTH),
      .NWRITE   (NWRITE),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (we),
      .wa        (wa),
      .rsv_en    (rsv_en),
      .rsv_addr  (rsv_addr),
      .busy      (busy),
      .busy_next (busy_next)
   );

   // Each read port samples write-first data (bypass from the same-edge
   // write) and the post-edge busy state, and holds while re is low.
   for (genvar g = 0; g < NREAD; g++) begin : g_read
      logic [WIDTH-1:0] rd_q;
      logic             rd_busy_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_q      <= '0;
            rd_busy_q <= 1'b0;
         end else if (re[g]) begin
            if ((ZERO_REG != 0) && (ra[g] == '0)) begin
               rd_q      <= '0;
               rd_busy_q <= 1'b0;
            end else begin
               rd_q      <= wr_hit[ra[g]] ? wr_data[ra[g]] : rf[ra[g]];
               rd_busy_q <= busy_next[ra[g]];
            end
         end
      end

      assign rd[g]      = rd_q;
      assign rd_busy[g] = rd_busy_q;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp
// Drives two register files side by side from the same inputs: one with
// register 0 hardwired (u_dut_z) and one without (u_dut_nz), both with two
// write ports. A behavioural model of each predicts every output.
// ----------------------------------------------------------------------------
module tb_regfile_mp;

   localparam int W  = 32;
   localparam int D  = 32;
   localparam int NR = 2;
   localparam int NW = 2;
   localparam int AW = 5;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NR-1:0]         re;
   logic [NR-1:0][AW-1:0] ra;
   logic [NW-1:0]         we;
   logic [NW-1:0][AW-1:0] wa;
   logic [NW-1:0][W-1:0]  wd;
   logic                  rsv_en;
   logic [AW-1:0]         rsv_addr;

   logic [NR-1:0][W-1:0]  rd_z, rd_nz;
   logic [NR-1:0]         rdb_z, rdb_nz;
   logic [D-1:0]          busy_z, busy_nz;

   int n_assert = 0;
   int n_fail   = 0;

   // Model state, index 0 = hardwired-zero instance, 1 = plain instance
   logic [W-1:0] m_rf   [2][D];
   logic         m_busy [2][D];
   logic [W-1:0] m_rd   [2][NR];
   logic         m_rdb  [2][NR];

   always #5 clk = ~clk;

   regfile_mp #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .NWRITE(NW), .ZERO_REG(1)) u_dut_z (
      .clk(clk), .rst_n(rst_n), .re(re), .ra(ra), .rd(rd_z), .rd_busy(rdb_z),
      .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy_z)
   );

   regfile_mp #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .NWRITE(NW), .ZERO_REG(0)) u_dut_nz (
      .clk(clk), .rst_n(rst_n), .re(re), .ra(ra), .rd(rd_nz), .rd_busy(rdb_nz),
      .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy_nz)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      re       = '0;
      ra       = '0;
      we       = '0;
      wa       = '0;
      wd       = '0;
      rsv_en   = 1'b0;
      rsv_addr = '0;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int a = 0; a < D; a++) begin
            m_rf[k][a]   = '0;
            m_busy[k][a] = 1'b0;
         end
         for (int r = 0; r < NR; r++) begin
            m_rd[k][r]  = '0;
            m_rdb[k][r] = 1'b0;
         end
      end
   endtask

   // One clock edge of the register file as the rules describe it: apply
   // writes in port order (later port wins), update the scoreboard (clear,
   // then reserve), then let enabled readers see the post-edge state.
   task automatic model_edge(input int k);
      logic [W-1:0] nrf [D];
      logic         nb  [D];
      bit           zero;
      zero = (k == 0);
      for (int a = 0; a < D; a++) begin
         nrf[a] = m_rf[k][a];
         nb[a]  = m_busy[k][a];
      end
      for (int p = 0; p < NW; p++) begin
         if (we[p] && !(zero && wa[p] == 0)) nrf[wa[p]] = wd[p];
         if (we[p]) nb[wa[p]] = 1'b0;
      end
      if (rsv_en) nb[rsv_addr] = 1'b1;
      if (zero) nb[0] = 1'b0;
      for (int r = 0; r < NR; r++) begin
         if (re[r]) begin
            if (zero && ra[r] == 0) begin
               m_rd[k][r]  = '0;
               m_rdb[k][r] = 1'b0;
            end else begin
               m_rd[k][r]  = nrf[ra[r]];
               m_rdb[k][r] = nb[ra[r]];
            end
         end
      end
      for (int a = 0; a < D; a++) begin
         m_rf[k][a]   = nrf[a];
         m_busy[k][a] = nb[a];
      end
   endtask

   task automatic checkOutput(input string step);
      logic [D-1:0] eb;
      for (int k = 0; k < 2; k++) begin
         for (int a = 0; a < D; a++) eb[a] = m_busy[k][a];
         for (int r = 0; r < NR; r++) begin
            chk($sformatf("%s i%0d rd%0d", step, k, r),
                64'(k == 0 ? rd_z[r] : rd_nz[r]), 64'(m_rd[k][r]));
            chk($sformatf("%s i%0d rd_busy%0d", step, k, r),
                64'(k == 0 ? rdb_z[r] : rdb_nz[r]), 64'(m_rdb[k][r]));
         end
         chk($sformatf("%s i%0d busy", step, k),
             64'(k == 0 ? busy_z : busy_nz), 64'(eb));
      end
   endtask

   // Inputs are set mid-cycle; advance one edge, sample 1 time unit later.
   task automatic applyStimulus(input string step);
      model_edge(0);
      model_edge(1);
      @(posedge clk);
      #1;
      checkOutput(step);
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      model_reset();
      #12;
      checkOutput("reset");
      @(posedge clk);
      #3 rst_n = 1'b1;

      // Reset mid-operation
      idle();
      we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF;
      re[0] = 1'b1; ra[0] = 5'd5;
      rsv_en = 1'b1; rsv_addr = 5'd9;
      applyStimulus("pre_reset");
      chk("pre_reset rd0 const", 64'(rd_z[0]), 64'h0000_0000_DEAD_BEEF);
      idle();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      checkOutput("async_reset");
      we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'h1111;
      rsv_en = 1'b1; rsv_addr = 5'd6;
      @(posedge clk);
      #1;
      checkOutput("held_in_reset");
      idle();
      #2 rst_n = 1'b1;
      re[0] = 1'b1; ra[0] = 5'd5;
      applyStimulus("post_reset_read");
      chk("post_reset r5 const", 64'(rd_z[0]), 64'h0);

      // Bypass
      idle();
      we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'h1234;
      re[0] = 1'b1; ra[0] = 5'd7;
      applyStimulus("bypass");
      chk("bypass rd0 const", 64'(rd_z[0]), 64'h1234);
      idle();
      re[0] = 1'b1; ra[0] = 5'd7;
      applyStimulus("reread");

      // Priority between write ports
      idle();
      we = 2'b11; wa[0] = 5'd3; wa[1] = 5'd3; wd[0] = 32'hAAAA; wd[1] = 32'hBBBB;
      re[0] = 1'b1; ra[0] = 5'd3;
      applyStimulus("priority_bypass");
      chk("priority rd0 const", 64'(rd_z[0]), 64'hBBBB);
      idle();
      re[1] = 1'b1; ra[1] = 5'd3;
      applyStimulus("priority_stored");

      // Zero register
      idle();
      we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hFFFFFFFF;
      rsv_en = 1'b1; rsv_addr = 5'd0;
      re[0] = 1'b1; ra[0] = 5'd0;
      applyStimulus("zero_reg");
      chk("zero_reg nz rd0 const", 64'(rd_nz[0]), 64'hFFFF_FFFF);
      chk("zero_reg nz busy0 const", 64'(busy_nz[0]), 64'h1);
      idle();
      re[0] = 1'b1; ra[0] = 5'd0;
      applyStimulus("zero_reread");

      // Scoreboard
      idle();
      rsv_en = 1'b1; rsv_addr = 5'd9;
      applyStimulus("reserve");
      chk("reserve busy9 const", 64'(busy_z[9]), 64'h1);
      idle();
      we[1] = 1'b1; wa[1] = 5'd9; wd[1] = 32'h9999;
      rsv_en = 1'b1; rsv_addr = 5'd9;
      re[1] = 1'b1; ra[1] = 5'd9;
      applyStimulus("set_beats_clear");
      chk("set_beats_clear busy9 const", 64'(busy_z[9]), 64'h1);
      idle();
      we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h4242;
      applyStimulus("clear");
      chk("clear busy9 const", 64'(busy_z[9]), 64'h0);

      // Hold: load port 1 then disable it while everything else moves
      idle();
      re[1] = 1'b1; ra[1] = 5'd7;
      rsv_en = 1'b1; rsv_addr = 5'd7;
      applyStimulus("hold_load");
      for (int c = 0; c < 3; c++) begin
         idle();
         ra[1] = 5'(c + 10);
         we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'(c + 32'h5000);
         rsv_en = 1'b1; rsv_addr = 5'(c + 10);
         applyStimulus($sformatf("hold%0d", c));
         chk($sformatf("hold%0d rd1 const", c), 64'(rd_z[1]), 64'h1234);
         chk($sformatf("hold%0d rd_busy1 const", c), 64'(rdb_z[1]), 64'h1);
      end

      // Random traffic concentrated on a few registers to force collisions
      for (int i = 0; i < 400; i++) begin
         idle();
         for (int p = 0; p < NW; p++) begin
            we[p] = 1'($urandom_range(0, 1));
            wa[p] = 5'($urandom_range(0, 7));
            wd[p] = $urandom;
         end
         for (int r = 0; r < NR; r++) begin
            re[r] = 1'($urandom_range(0, 1));
            ra[r] = 5'($urandom_range(0, 7));
         end
         rsv_en   = 1'($urandom_range(0, 1));
         rsv_addr = 5'($urandom_range(0, 7));
         if (i % 16 == 15) begin
            wa[0] = 5'($urandom_range(0, 31));
            ra[1] = 5'($urandom_range(0, 31));
         end
         applyStimulus($sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
